// File: rtl/fifo_drain_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_drain_pkg
//  Description : Shared definitions for the FIFO drain block: FSM state
//                encoding and default widths.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package fifo_drain_pkg;

  localparam int DEFAULT_FIFO_WIDTH = 16;
  localparam int DEFAULT_CNT_WIDTH  = 16;

  // Stream controller states, explicit 2-bit encoding.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } drain_state_e;

endpackage : fifo_drain_pkg
`default_nettype wire

// File: rtl/fifo_drain_skid.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_drain_skid
//  Description : 2-entry in-order buffer between the FIFO read port and the
//                valid/ready output stream. Entry 0 is always the head.
//  Ports       : clk, rst_n       - clock, synchronous active-low reset
//                wr_en_i/wr_data_i - write port (one word per cycle)
//                pop_i             - remove head (ignored while empty)
//                head_o/valid_o    - head entry and occupancy != 0
//                occ_o             - occupancy 0..2
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_drain_skid
  import fifo_drain_pkg::*;
#(
  parameter int WIDTH = DEFAULT_FIFO_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             valid_o,
  output logic [1:0]       occ_o
);

  logic [WIDTH-1:0] e0_q, e0_d;
  logic [WIDTH-1:0] e1_q, e1_d;
  logic [1:0]       occ_q, occ_d;
  logic             pop_ok;

  assign pop_ok = pop_i && (occ_q != 2'd0);

  always_comb begin
    e0_d  = e0_q;
    e1_d  = e1_q;
    occ_d = occ_q;
    unique case ({wr_en_i, pop_ok})
      2'b10: begin
        if (occ_q == 2'd0) e0_d = wr_data_i;
        else               e1_d = wr_data_i;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        e0_d  = e1_q;
        occ_d = occ_q - 2'd1;
      end
      2'b11: begin
        // Occupancy unchanged: head leaves, new word joins the tail.
        if (occ_q == 2'd2) begin
          e0_d = e1_q;
          e1_d = wr_data_i;
        end else begin
          e0_d = wr_data_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      e0_q  <= '0;
      e1_q  <= '0;
      occ_q <= 2'd0;
    end else begin
      e0_q  <= e0_d;
      e1_q  <= e1_d;
      occ_q <= occ_d;
    end
  end

  assign head_o  = e0_q;
  assign valid_o = (occ_q != 2'd0);
  assign occ_o   = occ_q;

endmodule : fifo_drain_skid
`default_nettype wire

// File: rtl/fifo_drain.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_drain
//  Description : Drains a synchronous FIFO (1-cycle read latency) into a
//                valid/ready stream. Reads are credit-limited so the 2-entry
//                output buffer can never overflow.
//  Ports       : clk, rst_n        - clock, synchronous active-low reset
//                enable            - request to stream
//                rd_en/data_out    - FIFO pop strobe / read data
//                empty/underflow   - FIFO status flags
//                m_valid/m_data/m_ready - output stream
//                busy              - state != IDLE
//                pop_count         - pops issued since reset (wraps)
//                err_underflow     - sticky underflow flag
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_drain
  import fifo_drain_pkg::*;
#(
  parameter int FIFO_WIDTH = DEFAULT_FIFO_WIDTH,
  parameter int CNT_WIDTH  = DEFAULT_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  output logic                  rd_en,
  input  logic [FIFO_WIDTH-1:0] data_out,
  input  logic                  empty,
  input  logic                  underflow,
  output logic                  m_valid,
  output logic [FIFO_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  pop_count,
  output logic                  err_underflow
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  drain_state_e          state_q, state_d;
  logic                  pending_q;
  logic [CNT_WIDTH-1:0]  pop_count_q;
  logic                  err_q;
  logic [1:0]            occ;
  logic                  pop;
  logic [2:0]            inflight;

  assign pop      = m_valid & m_ready;
  // Words already owned by the buffer: stored plus the one still in the
  // FIFO read pipeline. A same-cycle pop frees one slot early.
  assign inflight = {1'b0, occ} + {2'b00, pending_q};
  assign rd_en    = (state_q == RUN) && !empty &&
                    (inflight < (3'd2 + {2'b00, pop}));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (enable) state_d = RUN;
      RUN:  if (!enable) state_d = STOP;
      STOP: begin
        if (enable)                             state_d = RUN;
        else if (!pending_q && (occ == 2'd0))   state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pending_q   <= 1'b0;
      pop_count_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= rd_en;
      if (rd_en) pop_count_q <= pop_count_q + CNT_ONE;
      if (underflow) err_q <= 1'b1;
    end
  end

  // Read data is valid one cycle after the pop, exactly when pending is set.
  fifo_drain_skid #(
    .WIDTH (FIFO_WIDTH)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (pending_q),
    .wr_data_i (data_out),
    .pop_i     (pop),
    .head_o    (m_data),
    .valid_o   (m_valid),
    .occ_o     (occ)
  );

  assign busy          = (state_q != IDLE);
  assign pop_count     = pop_count_q;
  assign err_underflow = err_q;

endmodule : fifo_drain
`default_nettype wire

// File: doc/fifo_drain.md
FIFO_DRAIN -- requirements
Module: fifo_drain

Interface
REQ-001 The block SHALL have parameter FIFO_WIDTH, default 16, the width of the FIFO data word and the output stream word.
REQ-002 The block SHALL have parameter CNT_WIDTH, default 16, the width of the popped-word counter.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on posedge clk.
REQ-004 The block SHALL have port rst_n, input, 1 bit: synchronous, active-low reset, sampled on posedge clk.
REQ-005 The block SHALL have port enable, input, 1 bit: request to stream; sampled each cycle.
REQ-006 The block SHALL have port rd_en, output, 1 bit: pop strobe to the FIFO.
REQ-007 The block SHALL have port data_out, input, FIFO_WIDTH: FIFO read data, valid in the cycle after the edge that sampled rd_en=1.
REQ-008 The block SHALL have port empty, input, 1 bit: FIFO empty flag.
REQ-009 The block SHALL have port underflow, input, 1 bit: FIFO underflow flag.
REQ-010 The block SHALL have port m_valid, output, 1 bit: output stream word valid.
REQ-011 The block SHALL have port m_data, output, FIFO_WIDTH: output stream word.
REQ-012 The block SHALL have port m_ready, input, 1 bit: downstream accept; a transfer occurs on a posedge where m_valid=1 and m_ready=1.
REQ-013 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-014 The block SHALL have port pop_count, output, CNT_WIDTH: number of FIFO pops issued since reset.
REQ-015 The block SHALL have port err_underflow, output, 1 bit: sticky underflow error flag.

Function
REQ-016 The FSM SHALL have states IDLE, RUN and STOP; transitions: IDLE->RUN when enable=1; RUN->STOP when enable=0; STOP->IDLE when pending=0 and the buffer is empty; STOP->RUN when enable=1.
REQ-017 rd_en SHALL be combinational: rd_en = (state==RUN) and !empty and (occ + pending - pop) < 2, where occ is buffer occupancy (0..2), pending is a 1-bit register set on the edge that sampled rd_en=1, and pop = m_valid and m_ready.
REQ-018 On each posedge where pending=1, data_out SHALL be written into the 2-entry buffer; pending SHALL take that edge's rd_en value.
REQ-019 Latency SHALL be: a word popped at edge k appears on m_data with m_valid=1 after edge k+1, provided the buffer was empty before that edge.
REQ-020 The buffer SHALL be in-order; m_data SHALL be its head entry; m_valid SHALL equal (occ != 0); a simultaneous write and pop SHALL leave occ unchanged.
REQ-021 The buffer SHALL never overflow, because REQ-017 guarantees occ + pending never exceeds 2.
REQ-022 With m_ready held at 1 and the FIFO non-empty, rd_en SHALL be asserted every cycle, giving 1 word per cycle throughput.
REQ-023 When m_ready=0, m_data and m_valid SHALL hold stable until the transfer.
REQ-024 pop_count SHALL increment by 1 on each edge with rd_en=1 and SHALL wrap modulo 2^CNT_WIDTH.
REQ-025 err_underflow SHALL set on any edge where underflow=1 and SHALL clear only on reset.
REQ-026 When empty=1, rd_en SHALL be 0 in every state.
REQ-027 In IDLE and STOP, rd_en SHALL be 0, and in-flight or buffered words SHALL still drain to m_data.

Reset
REQ-028 On an edge with rst_n=0, the block SHALL go to state=IDLE with pending=0, occ=0, pop_count=0 and err_underflow=0; consequently m_valid=0, busy=0, rd_en=0 and m_data=0.
REQ-029 A reset asserted mid-stream SHALL discard buffered and in-flight words without emitting them; the first word after reset SHALL be a newly popped one.

Structure
REQ-030 The shared package SHALL hold the FSM state enum (drain_state_e: IDLE, RUN, STOP) and the default FIFO_WIDTH=16.
REQ-031 The 2-entry in-order buffer SHALL be a sub-module named fifo_drain_skid, with write port, head/valid and pop; the FSM, the credit logic and the counters SHALL stay in fifo_drain.

Verification
REQ-032 Reset then idle: rst_n=0 for 2 cycles, enable=0, empty=0 -> rd_en=0, m_valid=0, pop_count=0, busy=0.
REQ-033 Streaming: FIFO preloaded with 0x0001..0x0008, enable=1, m_ready=1 -> rd_en high for 8 consecutive cycles; m_data 0x0001..0x0008 on consecutive cycles starting 2 edges after the first rd_en; pop_count=8.
REQ-034 Backpressure: same preload, m_ready=0 for 5 cycles -> at most 2 pops, then rd_en=0, occ=2, m_data=0x0001 stable; after release, order is preserved and no word is lost.
REQ-035 Stop mid-stream: enable dropped after 3 pops, m_ready=1 -> state passes through STOP, 0x0001..0x0003 are all emitted, then IDLE with busy=0 and pop_count=3.
REQ-036 Empty and underflow: empty=1 with enable=1 -> rd_en stays 0; forcing underflow=1 for one cycle -> err_underflow=1 and it remains 1 until rst_n=0.
REQ-037 Reset mid-operation: rst_n=0 while occ=2 -> m_valid=0 on the next cycle, 0x0001 and 0x0002 are never emitted, and pop_count=0.
